// File: rtl/reg_file_sb.sv
// reg_file_sb: architectural register file with a per-register scoreboard.
//
// Holds NREGS registers of XLEN bits each. Register 0 is hardwired to zero.
// Alongside the data, a pending bit per register records that an issued
// instruction has reserved it. The pending bit clears when that result is
// written back.
//
// Ports
//   clk       rising-edge clock for all state
//   rst       asynchronous, active-low reset; clears data and pending bits
//   wr_en     write strobe; wr_addr/wr_data give destination and value
//   iss_en    issue strobe; sets the pending bit of iss_addr
//   flush     clears every pending bit (a same-edge write still lands)
//   rd_addr   NRD packed read addresses, port i at [i*AW +: AW]
//   rd_data   NRD packed read values, port i at [i*XLEN +: XLEN]
//   rd_busy   per-port pending flag of the addressed register
//   busy_cnt  number of registers currently marked pending
module reg_file_sb #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NRD    = 2,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREGS),
   localparam int CW    = $clog2(NREGS) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [XLEN-1:0]   wr_data,
   input  logic              iss_en,
   input  logic [AW-1:0]     iss_addr,
   input  logic              flush,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]    rd_busy,
   output logic [CW-1:0]     busy_cnt
);

   // An address is usable when it is a real, non-zero register.
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return (a != '0) && (int'(a) < NREGS);
   endfunction

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] pending;
   logic [NREGS-1:0] pend_nxt;
   logic             wr_ok;
   logic             iss_ok;
   logic [AW-1:0]    ra;
   logic [CW-1:0]    cnt;

   // Strobes are qualified with rst so that nothing, including the
   // combinational bypass path, leaks through while reset is held.
   assign wr_ok  = rst & wr_en  & addr_ok(wr_addr);
   assign iss_ok = rst & iss_en & addr_ok(iss_addr);

   // Priority: write clears, issue sets (new producer wins), flush clears all.
   always_comb begin
      pend_nxt = pending;
      if (wr_ok)
         pend_nxt[wr_addr] = 1'b0;
      if (iss_ok)
         pend_nxt[iss_addr] = 1'b1;
      if (flush)
         pend_nxt = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
         pending <= '0;
      end else begin
         if (wr_ok)
            regs[wr_addr] <= wr_data;
         pending <= pend_nxt;
      end
   end

   // Zero-latency reads; a matching in-flight write is forwarded and
   // reported as not busy because its result is available right now.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      ra      = '0;
      for (int i = 0; i < NRD; i++) begin
         ra = rd_addr[i*AW +: AW];
         if ((BYPASS != 0) && wr_ok && (ra == wr_addr)) begin
            rd_data[i*XLEN +: XLEN] = wr_data;
         end else if (addr_ok(ra)) begin
            rd_data[i*XLEN +: XLEN] = regs[ra];
            rd_busy[i]              = pending[ra];
         end
      end
   end

   // Bit 0 is never set, so the count tops out at NREGS-1 and CW bits
   // cannot wrap.
   always_comb begin
      cnt = '0;
      for (int i = 1; i < NREGS; i++)
         cnt = cnt + CW'(pending[i]);
   end

   assign busy_cnt = cnt;

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, data width of each register.
REQ-002 The block SHALL have parameter NREGS, default 32, number of architectural registers; AW = clog2(NREGS) address bits, CW = clog2(NREGS)+1 count bits.
REQ-003 The block SHALL have parameter NRD, default 2, number of independent read ports.
REQ-004 The block SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 wr_en  input  1  write strobe.
REQ-008 wr_addr  input  AW  destination register of write.
REQ-009 wr_data  input  XLEN  write data.
REQ-010 iss_en  input  1  issue strobe: marks iss_addr pending (scoreboard set).
REQ-011 iss_addr  input  AW  register reserved by the issuing instruction.
REQ-012 flush  input  1  clears all pending marks.
REQ-013 rd_addr  input  NRD*AW  packed read addresses, port i at bits [i*AW +: AW].
REQ-014 rd_data  output  NRD*XLEN  packed read data, port i at bits [i*XLEN +: XLEN].
REQ-015 rd_busy  output  NRD  port i register has a pending, unwritten result.
REQ-016 busy_cnt  output  CW  number of registers currently marked pending.

Function
REQ-017 Register 0 SHALL always read 0, SHALL ignore writes, SHALL never be marked pending.
REQ-018 Addresses >= NREGS SHALL read 0 with busy 0; writes/issues to them SHALL be ignored.
REQ-019 On rising clk with wr_en=1 and valid non-zero wr_addr, reg[wr_addr] SHALL take wr_data and its pending bit SHALL clear.
REQ-020 On rising clk with iss_en=1 and valid non-zero iss_addr, pending[iss_addr] SHALL set.
REQ-021 Same-edge write and issue to the same address: data SHALL be written and pending SHALL end set (new producer wins).
REQ-022 flush=1 SHALL clear every pending bit on that edge, overriding a same-edge issue; a same-edge write SHALL still update data.
REQ-023 Reads SHALL be combinational (zero-latency) on all NRD ports independently; multiple ports may address the same register.
REQ-024 With BYPASS=1, a port whose rd_addr equals a valid non-zero wr_addr while wr_en=1 SHALL return wr_data and rd_busy=0 in that same cycle.
REQ-025 With BYPASS=0, reads SHALL return only stored state; written data SHALL be visible the cycle after the edge.
REQ-026 rd_busy[i] SHALL reflect the stored pending bit of rd_addr[i], masked per REQ-024.
REQ-027 busy_cnt SHALL equal the population count of stored pending bits, range 0..NREGS-1, never wrapping.
REQ-028 Unused upper encodings and X-free outputs: every output SHALL be driven to a defined value every cycle.

Reset
REQ-029 rst=0 SHALL immediately, independent of clk, clear all registers to 0 and all pending bits to 0, giving rd_data=0, rd_busy=0, busy_cnt=0.
REQ-030 Writes, issues and flushes SHALL be ignored while rst=0; reset deasserted mid-operation SHALL leave no pending marks.
REQ-031 First clk edge after rst rises SHALL process inputs normally.

Verification
REQ-032 Reset then read all addresses on both ports -> rd_data=0, rd_busy=0, busy_cnt=0.
REQ-033 Write x0=0xDEADBEEF, issue x0 -> read x0 returns 0, busy 0, busy_cnt 0.
REQ-034 Issue x5, next cycle read x5 -> rd_busy=1, busy_cnt=1; write x5=0x12345678 -> BYPASS=1 same-cycle rd_data=0x12345678, rd_busy=0; after edge busy_cnt=0.
REQ-035 Same edge: write x7=0xA5 and issue x7 -> after edge x7 reads 0xA5, rd_busy=1, busy_cnt=1.
REQ-036 Issue x1..x31 over 31 cycles -> busy_cnt=31; flush with concurrent issue x3 -> busy_cnt=0, all rd_busy=0.
REQ-037 Write x9=0x55, assert rst=0 between edges -> x9 reads 0 immediately, busy_cnt=0; BYPASS=0 build: write x4=0x1 -> same-cycle read shows old 0, next cycle 0x1.
